// File: rtl/ov7670_sccb_config.sv
// rtl/ov7670_sccb_config.sv - OV7670 reset, boot wait and SCCB register-ROM sequencer
//
// Ports:
//   clk, rst        system clock, asynchronous active-low reset
//   start           single-cycle pulse, reruns the whole sequence from IDLE/DONE
//   rom_addr        register ROM address (rom_data valid one cycle later)
//   rom_data        {reg, val}; 16'hFFFF = end marker, 16'hFFF0 = delay entry
//   sioc            SCCB clock
//   siod_o/oe/i     SCCB data: oe=1 drives siod_o, oe=0 releases to the pull-up
//   cam_resetn      camera RESET pin (active-low), cam_pwdn tied low
//   busy, done      sequence running / sequence finished (camera format valid)
//   nack_cnt        high ACK samples seen in the last sequence, saturating
`timescale 1ns/1ps
module ov7670_sccb_config #(
    parameter int         c_sclk_div  = 250,
    parameter int         c_boot_wait = 1_000_000,
    parameter int         c_reg_wait  = 100_000,
    parameter logic [7:0] c_dev_addr  = 8'h42,
    parameter int         c_nb_rom    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [c_nb_rom-1:0] rom_addr,
    input  logic [15:0]         rom_data,
    output logic                sioc,
    output logic                siod_o,
    output logic                siod_oe,
    input  logic                siod_i,
    output logic                cam_resetn,
    output logic                cam_pwdn,
    output logic                busy,
    output logic                done,
    output logic [7:0]          nack_cnt
);

    localparam int                  c_div_w     = $clog2(c_sclk_div);
    localparam logic [c_div_w-1:0]  c_div_last  = c_div_w'(c_sclk_div - 1);
    localparam logic [31:0]         c_boot_last = 32'(c_boot_wait - 1);
    localparam logic [31:0]         c_reg_last  = 32'(c_reg_wait - 1);
    localparam logic [c_nb_rom-1:0] c_addr_last = '1;

    typedef enum logic [3:0] {
        S_IDLE, S_CAM_RST, S_BOOT_WAIT, S_FETCH, S_DECODE,
        S_START, S_BIT, S_STOP, S_GAP, S_DELAY, S_DONE
    } state_t;

    state_t               state, state_n;
    logic [c_div_w-1:0]   div_cnt, div_n;
    logic [1:0]           qtr, qtr_n;
    logic [3:0]           bit_idx, bit_n;
    logic [1:0]           byte_idx, byte_n;
    logic [31:0]          wait_cnt, wait_n;
    logic [7:0]           reg_byte, reg_n;
    logic [7:0]           val_byte, val_n;
    logic [7:0]           nack_n;
    logic [c_nb_rom-1:0]  addr_n;
    logic                 qtr_end;
    logic                 entry_done;
    logic [7:0]           tx_byte;
    logic                 sda_n, sioc_n;
    logic                 busy_n, done_n, cam_resetn_n;

    assign cam_pwdn = 1'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            div_cnt    <= '0;
            qtr        <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            wait_cnt   <= '0;
            reg_byte   <= '0;
            val_byte   <= '0;
            nack_cnt   <= '0;
            rom_addr   <= '0;
            sioc       <= 1'b1;
            siod_o     <= 1'b1;
            siod_oe    <= 1'b0;
            cam_resetn <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            div_cnt    <= div_n;
            qtr        <= qtr_n;
            bit_idx    <= bit_n;
            byte_idx   <= byte_n;
            wait_cnt   <= wait_n;
            reg_byte   <= reg_n;
            val_byte   <= val_n;
            nack_cnt   <= nack_n;
            rom_addr   <= addr_n;
            sioc       <= sioc_n;
            siod_o     <= sda_n;
            siod_oe    <= ~sda_n;
            cam_resetn <= cam_resetn_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        div_n      = div_cnt;
        qtr_n      = qtr;
        bit_n      = bit_idx;
        byte_n     = byte_idx;
        wait_n     = wait_cnt;
        reg_n      = reg_byte;
        val_n      = val_byte;
        nack_n     = nack_cnt;
        addr_n     = rom_addr;
        entry_done = 1'b0;
        qtr_end    = (div_cnt == c_div_last);
        tx_byte    = c_dev_addr;
        sda_n      = 1'b1;
        sioc_n     = 1'b1;

        case (state)
            S_IDLE: begin
                // Leaving reset always launches a full sequence.
                state_n = S_CAM_RST;
                wait_n  = '0;
                addr_n  = '0;
                nack_n  = '0;
            end
            S_CAM_RST: begin
                if (wait_cnt == c_boot_last) begin
                    state_n = S_BOOT_WAIT;
                    wait_n  = '0;
                end else begin
                    wait_n = wait_cnt + 32'd1;
                end
            end
            S_BOOT_WAIT: begin
                if (wait_cnt == c_boot_last) begin
                    state_n = S_FETCH;
                    wait_n  = '0;
                end else begin
                    wait_n = wait_cnt + 32'd1;
                end
            end
            S_FETCH: begin
                state_n = S_DECODE;
            end
            S_DECODE: begin
                reg_n  = rom_data[15:8];
                val_n  = rom_data[7:0];
                div_n  = '0;
                qtr_n  = '0;
                wait_n = '0;
                if (rom_data == 16'hFFFF) begin
                    state_n = S_DONE;
                end else if (rom_data == 16'hFFF0) begin
                    state_n = S_DELAY;
                end else begin
                    state_n = S_START;
                end
            end
            S_START: begin
                if (!qtr_end) begin
                    div_n = div_cnt + c_div_w'(1);
                end else begin
                    div_n = '0;
                    if (qtr == 2'd1) begin
                        state_n = S_BIT;
                        qtr_n   = '0;
                        bit_n   = '0;
                        byte_n  = '0;
                    end else begin
                        qtr_n = qtr + 2'd1;
                    end
                end
            end
            S_BIT: begin
                // ACK is sampled at the very end of the third quarter, i.e.
                // just before the slave may release SDA after the SCL high phase.
                if (qtr_end && qtr == 2'd2 && bit_idx == 4'd8 && siod_i &&
                    nack_cnt != 8'hFF) begin
                    nack_n = nack_cnt + 8'd1;
                end
                if (!qtr_end) begin
                    div_n = div_cnt + c_div_w'(1);
                end else begin
                    div_n = '0;
                    if (qtr == 2'd3) begin
                        qtr_n = '0;
                        if (bit_idx == 4'd8) begin
                            bit_n = '0;
                            if (byte_idx == 2'd2) begin
                                state_n = S_STOP;
                            end else begin
                                byte_n = byte_idx + 2'd1;
                            end
                        end else begin
                            bit_n = bit_idx + 4'd1;
                        end
                    end else begin
                        qtr_n = qtr + 2'd1;
                    end
                end
            end
            S_STOP: begin
                if (!qtr_end) begin
                    div_n = div_cnt + c_div_w'(1);
                end else begin
                    div_n = '0;
                    if (qtr == 2'd2) begin
                        state_n = S_GAP;
                        qtr_n   = '0;
                    end else begin
                        qtr_n = qtr + 2'd1;
                    end
                end
            end
            S_GAP: begin
                if (!qtr_end) begin
                    div_n = div_cnt + c_div_w'(1);
                end else begin
                    div_n = '0;
                    qtr_n = qtr + 2'd1;
                    if (qtr == 2'd3) begin
                        entry_done = 1'b1;
                    end
                end
            end
            S_DELAY: begin
                if (wait_cnt == c_reg_last) begin
                    wait_n     = '0;
                    entry_done = 1'b1;
                end else begin
                    wait_n = wait_cnt + 32'd1;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_n = S_CAM_RST;
                    wait_n  = '0;
                    addr_n  = '0;
                    nack_n  = '0;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // The last ROM slot ends the sequence even without an end marker.
        if (entry_done) begin
            if (rom_addr == c_addr_last) begin
                state_n = S_DONE;
            end else begin
                addr_n  = rom_addr + c_nb_rom'(1);
                state_n = S_FETCH;
            end
        end

        // Outputs are decoded from the next state so they register in step with it.
        case (byte_n)
            2'd1:    tx_byte = reg_n;
            2'd2:    tx_byte = val_n;
            default: tx_byte = c_dev_addr;
        endcase

        case (state_n)
            S_START: begin
                sda_n = (qtr_n == 2'd0);
            end
            S_BIT: begin
                sioc_n = qtr_n[1];
                sda_n  = (bit_n == 4'd8) ? 1'b1 : tx_byte[3'd7 - bit_n[2:0]];
            end
            S_STOP: begin
                sioc_n = (qtr_n != 2'd0);
                sda_n  = (qtr_n == 2'd2);
            end
            default: begin
                sioc_n = 1'b1;
                sda_n  = 1'b1;
            end
        endcase

        busy_n       = !(state_n == S_IDLE || state_n == S_DONE);
        done_n       = (state_n == S_DONE);
        cam_resetn_n = !(state_n == S_IDLE || state_n == S_CAM_RST);
    end

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// tb/tb_ov7670_sccb_config.sv - randomized waveform-model bench for ov7670_sccb_config
`timescale 1ns/1ps
module tb_ov7670_sccb_config;

    localparam int Q = 2;
    localparam int B = 10;
    localparam int W = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        siod_i = 1'b1;
    logic [1:0]  rom_addr;
    logic [15:0] rom_data = 16'h0000;
    logic        sioc, siod_o, siod_oe, cam_resetn, cam_pwdn, busy, done;
    logic [7:0]  nack_cnt;

    ov7670_sccb_config #(
        .c_sclk_div (Q),
        .c_boot_wait(B),
        .c_reg_wait (W),
        .c_dev_addr (8'h42),
        .c_nb_rom   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .sioc      (sioc),
        .siod_o    (siod_o),
        .siod_oe   (siod_oe),
        .siod_i    (siod_i),
        .cam_resetn(cam_resetn),
        .cam_pwdn  (cam_pwdn),
        .busy      (busy),
        .done      (done),
        .nack_cnt  (nack_cnt)
    );

    always #5 clk = ~clk;

    logic [15:0] rom_mem [4];
    bit          ack_val [12];

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    typedef struct packed {
        logic       sioc;
        logic       sda;
        logic       cam;
        logic       bsy;
        logic       dn;
        logic [1:0] addr;
        logic [7:0] nack;
        logic       din;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] mbytes[$];
    logic [7:0] cap[$];
    int vectors = 0;
    int miscompares = 0;
    int ntrans, low_cnt, first_start, done_idx;

    task automatic check(input string name, input int act, input int want);
        vectors++;
        if (act != want) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    task automatic push(input logic sc, input logic sd, input logic cm, input logic bz,
                        input logic dn, input logic [1:0] ad, input logic [7:0] nk,
                        input logic di, input int n);
        exp_t e;
        e.sioc = sc; e.sda = sd; e.cam = cm; e.bsy = bz; e.dn = dn;
        e.addr = ad; e.nack = nk; e.din = di;
        for (int k = 0; k < n; k++) expq.push_back(e);
    endtask

    // Expected per-cycle waveform of one full sequence, built from the bus timing rules.
    task automatic gen_seq();
        logic [7:0]  nk;
        logic [7:0]  bytes [3];
        logic [15:0] ent;
        logic [1:0]  ad;
        logic        a, b;
        int          ab;
        expq.delete();
        mbytes.delete();
        nk = 0; ab = 0; ad = 0;
        push(1, 1, 0, 1, 0, 0, nk, 1, B);
        push(1, 1, 1, 1, 0, 0, nk, 1, B);
        for (int n = 0; n < 4; n++) begin
            ad = 2'(n);
            ent = rom_mem[n];
            push(1, 1, 1, 1, 0, ad, nk, 1, 2);
            if (ent == 16'hFFFF) break;
            if (ent == 16'hFFF0) begin
                push(1, 1, 1, 1, 0, ad, nk, 1, W);
            end else begin
                push(1, 1, 1, 1, 0, ad, nk, 1, Q);
                push(1, 0, 1, 1, 0, ad, nk, 1, Q);
                bytes[0] = 8'h42; bytes[1] = ent[15:8]; bytes[2] = ent[7:0];
                for (int j = 0; j < 3; j++) begin
                    mbytes.push_back(bytes[j]);
                    for (int k = 0; k < 8; k++) begin
                        b = bytes[j][7-k];
                        push(0, b, 1, 1, 0, ad, nk, 1, 2*Q);
                        push(1, b, 1, 1, 0, ad, nk, 1, 2*Q);
                    end
                    a = ack_val[ab];
                    ab++;
                    push(0, 1, 1, 1, 0, ad, nk, a, 2*Q);
                    push(1, 1, 1, 1, 0, ad, nk, a, Q);
                    if (a && nk != 8'hFF) nk = nk + 8'd1;
                    push(1, 1, 1, 1, 0, ad, nk, a, Q);
                end
                push(0, 0, 1, 1, 0, ad, nk, 1, Q);
                push(1, 0, 1, 1, 0, ad, nk, 1, Q);
                push(1, 1, 1, 1, 0, ad, nk, 1, Q);
                push(1, 1, 1, 1, 0, ad, nk, 1, 4*Q);
            end
            if (n == 3) break;
        end
        push(1, 1, 1, 0, 1, ad, nk, 1, 4);
    endtask

    task automatic run_seq(input int start_idx, input int abort_idx);
        logic        ps, pb, bm;
        logic [7:0]  sh;
        logic [15:0] act, want;
        exp_t        e;
        int          bc;
        ps = 1; pb = 1; bc = 0; sh = 0;
        cap.delete();
        ntrans = 0; low_cnt = 0; first_start = -1; done_idx = -1;
        for (int i = 0; i < expq.size(); i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            e = expq[i];
            siod_i = e.din;
            act  = {sioc, siod_o, siod_oe, cam_resetn, busy, done, rom_addr, nack_cnt};
            want = {e.sioc, e.sda, ~e.sda, e.cam, e.bsy, e.dn, e.addr, e.nack};
            vectors++;
            if (act !== want) begin
                miscompares++;
                $display("FAIL cycle %0d outputs: got %h want %h", i, act, want);
            end
            bm = siod_oe ? siod_o : 1'b1;
            if (sioc && ps && pb && !bm) begin
                ntrans++;
                bc = 0;
                if (first_start < 0) first_start = i;
            end else if (sioc && !ps) begin
                if (bc < 8) sh = {sh[6:0], bm};
                bc++;
                if (bc == 9) begin
                    cap.push_back(sh);
                    bc = 0;
                end
            end
            if (!cam_resetn && busy) low_cnt++;
            if (done && done_idx < 0) done_idx = i;
            ps = sioc;
            pb = bm;
            if (i == start_idx) start = 1'b1;
            if (i == abort_idx) begin
                #2;
                rst = 1'b0;
                #1;
                check("abort_sioc", int'(sioc), 1);
                check("abort_oe", int'(siod_oe), 0);
                check("abort_busy", int'(busy), 0);
                check("abort_cam_resetn", int'(cam_resetn), 0);
                check("abort_rom_addr", int'(rom_addr), 0);
                siod_i = 1'b1;
                return;
            end
        end
        siod_i = 1'b1;
    endtask

    task automatic check_bytes(input string tag);
        check({tag, "_nbytes"}, cap.size(), mbytes.size());
        for (int i = 0; i < cap.size() && i < mbytes.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), int'(cap[i]), int'(mbytes[i]));
    endtask

    function automatic logic [15:0] rand_write();
        logic [15:0] r;
        r = 16'($urandom);
        if (r[15:4] == 12'hFFF) r[15] = 1'b0;
        return r;
    endfunction

    initial begin
        rom_mem[0] = 16'h1280; rom_mem[1] = 16'hFFF0;
        rom_mem[2] = 16'hFFFF; rom_mem[3] = 16'h0000;
        foreach (ack_val[k]) ack_val[k] = 1'b0;

        repeat (3) @(posedge clk);
        #3;
        check("rst_sioc", int'(sioc), 1);
        check("rst_siod_o", int'(siod_o), 1);
        check("rst_siod_oe", int'(siod_oe), 0);
        check("rst_cam_resetn", int'(cam_resetn), 0);
        check("rst_cam_pwdn", int'(cam_pwdn), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_nack", int'(nack_cnt), 0);
        check("rst_rom_addr", int'(rom_addr), 0);

        // Write, delay, end marker; a start pulse mid-write must be ignored.
        gen_seq();
        rst = 1'b1;
        run_seq(100, -1);
        check("seq1_cam_low", low_cnt, B);
        check("seq1_first_start", first_start, 24);
        check("seq1_done_at", done_idx, 280);
        check("seq1_nbytes", cap.size(), 3);
        if (cap.size() == 3) begin
            check("seq1_dev", int'(cap[0]), 8'h42);
            check("seq1_reg", int'(cap[1]), 8'h12);
            check("seq1_val", int'(cap[2]), 8'h80);
        end
        check("seq1_nack", int'(nack_cnt), 0);
        check("seq1_rom_addr", int'(rom_addr), 2);
        check("seq1_done", int'(done), 1);

        // Two writes with every ACK high.
        rom_mem[0] = rand_write(); rom_mem[1] = rand_write();
        rom_mem[2] = 16'hFFFF;     rom_mem[3] = rand_write();
        foreach (ack_val[k]) ack_val[k] = 1'b1;
        gen_seq();
        start = 1'b1;
        run_seq(-1, -1);
        check("seq2_nack", int'(nack_cnt), 6);
        check("seq2_done", int'(done), 1);
        check("seq2_trans", ntrans, 2);
        check_bytes("seq2");

        // Asynchronous reset during bit 3 of the register byte.
        foreach (rom_mem[k]) rom_mem[k] = rand_write();
        foreach (ack_val[k]) ack_val[k] = ($urandom_range(0, 3) == 0);
        gen_seq();
        start = 1'b1;
        run_seq(-1, 2*B + 2 + 2*Q + 36*Q + 13*Q);
        repeat (2) @(posedge clk);
        #3;
        check("held_busy", int'(busy), 0);
        check("held_sioc", int'(sioc), 1);

        // Restart after release: four writes, no end marker.
        foreach (rom_mem[k]) rom_mem[k] = rand_write();
        foreach (ack_val[k]) ack_val[k] = ($urandom_range(0, 3) == 0);
        gen_seq();
        rst = 1'b1;
        run_seq(-1, -1);
        check("seq4_trans", ntrans, 4);
        check("seq4_rom_addr", int'(rom_addr), 3);
        check("seq4_done", int'(done), 1);
        check_bytes("seq4");

        // Random mixes of writes, delays and end markers.
        for (int s = 0; s < 3; s++) begin
            foreach (rom_mem[k]) begin
                int r;
                r = $urandom_range(0, 9);
                rom_mem[k] = (r < 6) ? rand_write() : (r < 8) ? 16'hFFF0 : 16'hFFFF;
            end
            foreach (ack_val[k]) ack_val[k] = ($urandom_range(0, 1) == 1);
            gen_seq();
            start = 1'b1;
            run_seq(($urandom_range(0, 1) == 1) ? 40 : -1, -1);
            check($sformatf("rand%0d_trans", s), ntrans * 3, mbytes.size());
            check_bytes($sformatf("rand%0d", s));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
